// File: rtl/xm23_pkg.sv
// xm23_pkg: shared XM23 core types and constants
package xm23_pkg;
    typedef enum logic [1:0] {INIT = 2'd0, HALT = 2'd1, RUN = 2'd2, STEP = 2'd3} pipe_state_t;
    localparam int XM23_WORD_W = 16;
    localparam logic [XM23_WORD_W-1:0] XM23_NOP = 16'h0000;
endpackage

// File: rtl/xm23_pipe_ctrl_if.sv
// xm23_pipe_ctrl_if: datapath-side control/status bundle of the pipeline sequencer
interface xm23_pipe_ctrl_if #(parameter int CNT_W = 32);
    logic run, step, bkpt, imem_ready, dmem_wait, hazard, branch_taken;
    logic fetch_en, decode_en, exec_en, fd_nop, de_nop, pc_load, halted;
    logic [1:0] state;
    logic [CNT_W-1:0] adv_cnt;
    modport master (
        output run, step, bkpt, imem_ready, dmem_wait, hazard, branch_taken,
        input fetch_en, decode_en, exec_en, fd_nop, de_nop, pc_load, halted, state, adv_cnt
    );
    modport slave (
        input run, step, bkpt, imem_ready, dmem_wait, hazard, branch_taken,
        output fetch_en, decode_en, exec_en, fd_nop, de_nop, pc_load, halted, state, adv_cnt
    );
endinterface

// File: rtl/xm23_pipe_ctrl.sv
// xm23_pipe_ctrl: run/halt/step sequencer producing per-stage enables and NOP strobes
module xm23_pipe_ctrl
    import xm23_pkg::*;
#(
    parameter int STARTUP_CYCLES = 4,
    parameter int CNT_W = 32
) (
    input logic clock,
    input logic reset_n,
    xm23_pipe_ctrl_if.slave bus
);
    localparam logic [7:0] INIT_LOAD = 8'(STARTUP_CYCLES - 1);
    pipe_state_t state_q, nxt;
    logic [7:0] init_cnt;
    logic step_q, halted_q, adv, bubble;
    logic [CNT_W-1:0] adv_cnt_q;
    always_comb begin
        adv = (state_q == RUN || state_q == STEP) && !bus.dmem_wait;
        // a taken branch flushes the hazard, so it never stalls decode
        bubble = adv && bus.hazard && !bus.branch_taken;
        bus.exec_en = adv;
        bus.decode_en = adv && !bubble;
        bus.fetch_en = adv && !bubble && bus.imem_ready && !bus.branch_taken;
        bus.pc_load = adv && bus.branch_taken;
        bus.fd_nop = adv && !bubble && (bus.branch_taken || !bus.imem_ready);
        bus.de_nop = adv && (bubble || bus.branch_taken);
        bus.state = state_q;
        bus.halted = halted_q;
        bus.adv_cnt = adv_cnt_q;
        nxt = state_q;
        case (state_q)
            INIT: nxt = init_cnt == 8'd0 ? (bus.run ? RUN : HALT) : INIT;
            HALT: nxt = bus.run ? RUN : (bus.step && !step_q) ? STEP : HALT;
            RUN: nxt = (!bus.run || (bus.bkpt && adv)) ? HALT : RUN;
            default: nxt = adv ? HALT : STEP;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            halted_q <= 1'b0;
            init_cnt <= INIT_LOAD;
            step_q <= 1'b0;
            adv_cnt_q <= '0;
        end else begin
            state_q <= nxt;
            halted_q <= nxt == HALT;
            step_q <= bus.step;
            if (state_q == INIT && init_cnt != 8'd0) init_cnt <= init_cnt - 8'd1;
            if (adv) adv_cnt_q <= adv_cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_xm23_pipe_ctrl.sv
// tb_xm23_pipe_ctrl: directed vector bench for the pipeline sequencer
module tb_xm23_pipe_ctrl;
    import xm23_pkg::*;
    typedef struct {
        logic dmem, haz, br, imr;
        logic [5:0] exp;
    } vec_t;
    logic clock = 1'b0;
    logic reset_n;
    int errors = 0;
    int checks = 0;
    logic [3:0] exp_cnt;
    vec_t vecs [8];
    xm23_pipe_ctrl_if #(.CNT_W(4)) bus ();
    xm23_pipe_ctrl #(.STARTUP_CYCLES(4), .CNT_W(4)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    always #5 clock = ~clock;
    function automatic logic [5:0] outs();
        return {bus.fetch_en, bus.decode_en, bus.exec_en, bus.fd_nop, bus.de_nop, bus.pc_load};
    endfunction
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b111000};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b011100};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'b001010};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'b011111};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b011111};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'b000000};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b001010};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'b000000};
        reset_n = 1'b0;
        bus.run = 1'b1; bus.step = 1'b0; bus.bkpt = 1'b0; bus.imem_ready = 1'b1;
        bus.dmem_wait = 1'b0; bus.hazard = 1'b0; bus.branch_taken = 1'b0;
        #2;
        chk("rst_state", int'(bus.state), int'(INIT));
        chk("rst_outs", int'(outs()), 0);
        chk("rst_halted", int'(bus.halted), 0);
        chk("rst_cnt", int'(bus.adv_cnt), 0);
        tick();
        reset_n = 1'b1;
        exp_cnt = 4'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("init_state", int'(bus.state), int'(INIT));
            chk("init_exec", int'(bus.exec_en), 0);
            tick();
        end
        chk("run_state", int'(bus.state), int'(RUN));
        chk("first_exec", int'(bus.exec_en), 1);
        tick();
        exp_cnt++;
        chk("first_cnt", int'(bus.adv_cnt), int'(exp_cnt));
        for (int i = 0; i < 8; i++) begin
            bus.dmem_wait = vecs[i].dmem;
            bus.hazard = vecs[i].haz;
            bus.branch_taken = vecs[i].br;
            bus.imem_ready = vecs[i].imr;
            #1;
            chk($sformatf("vec%0d_outs", i), int'(outs()), int'(vecs[i].exp));
            tick();
            if (vecs[i].exp[3]) exp_cnt++;
            chk($sformatf("vec%0d_cnt", i), int'(bus.adv_cnt), int'(exp_cnt));
        end
        bus.dmem_wait = 1'b0; bus.hazard = 1'b0; bus.branch_taken = 1'b0; bus.imem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_cnt++;
            chk("wrap_cnt", int'(bus.adv_cnt), int'(exp_cnt));
        end
        bus.bkpt = 1'b1; bus.branch_taken = 1'b1; bus.step = 1'b1;
        #1;
        chk("bkpt_pc_load", int'(bus.pc_load), 1);
        tick();
        exp_cnt++;
        bus.bkpt = 1'b0; bus.branch_taken = 1'b0;
        chk("bkpt_state", int'(bus.state), int'(HALT));
        chk("bkpt_halted", int'(bus.halted), 1);
        bus.run = 1'b0;
        #1;
        chk("halt_exec", int'(bus.exec_en), 0);
        tick();
        chk("halt_hold", int'(bus.state), int'(HALT));
        bus.step = 1'b0;
        tick();
        chk("no_stale_step", int'(bus.state), int'(HALT));
        chk("halt_cnt", int'(bus.adv_cnt), int'(exp_cnt));
        bus.step = 1'b1; bus.dmem_wait = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("step_stall_state", int'(bus.state), int'(STEP));
            chk("step_stall_exec", int'(bus.exec_en), 0);
            tick();
        end
        bus.dmem_wait = 1'b0;
        #1;
        chk("step_exec", int'(bus.exec_en), 1);
        tick();
        exp_cnt++;
        chk("step_done_state", int'(bus.state), int'(HALT));
        chk("step_done_halted", int'(bus.halted), 1);
        chk("step_done_exec", int'(bus.exec_en), 0);
        chk("step_cnt", int'(bus.adv_cnt), int'(exp_cnt));
        bus.step = 1'b0; bus.run = 1'b1;
        tick();
        chk("resume_exec", int'(bus.exec_en), 1);
        bus.hazard = 1'b1; bus.branch_taken = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("arst_outs", int'(outs()), 0);
        chk("arst_state", int'(bus.state), int'(INIT));
        chk("arst_halted", int'(bus.halted), 0);
        chk("arst_cnt", int'(bus.adv_cnt), 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("reinit_state", int'(bus.state), int'(INIT));
        chk("reinit_outs", int'(outs()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/xm23_pipe_ctrl.md
# xm23_pipe_ctrl

Pipeline sequencer for the XM23 CPU core. It sits beside the fetch/decode/execute datapath and runs on the divided global `clock`. It owns the run/halt/single-step state machine and a post-reset startup delay. Each cycle it turns stall, hazard and branch indications into per-stage enables, NOP-insert strobes and a PC-load strobe.

## Interface
Parameters:
- `STARTUP_CYCLES`, default 4: cycles spent in INIT after reset release; legal range 1..255.
- `CNT_W`, default 32: width of the advance counter.

Ports:
- `clock`  in  1  global CPU clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 requests free-running execution.
- `step`  in  1  single-step request; a rising edge is detected internally.
- `bkpt`  in  1  breakpoint hit, from decode.
- `imem_ready`  in  1  fetch word available this cycle.
- `dmem_wait`  in  1  data memory busy; freezes the whole pipeline.
- `hazard`  in  1  load-use hazard, from decode.
- `branch_taken`  in  1  taken branch resolved in execute.
- `fetch_en`  out  1  PC / F-D register advance.
- `decode_en`  out  1  D-E register advance.
- `exec_en`  out  1  execute / writeback commit.
- `fd_nop`  out  1  load NOP (`16'h0000`) into the F-D register.
- `de_nop`  out  1  load NOP into the D-E register.
- `pc_load`  out  1  PC takes the branch target.
- `state`  out  2  encoding: INIT=0, HALT=1, RUN=2, STEP=3.
- `halted`  out  1  equals (`state` == HALT).
- `adv_cnt`  out  CNT_W  count of advance cycles.

## Operation
- States:
  - INIT: down-counter loads `STARTUP_CYCLES`-1 at reset and decrements each cycle. At 0, go to RUN if `run`=1, else to HALT.
  - HALT: `run`=1 goes to RUN; otherwise a step rising edge goes to STEP; `run` has priority.
  - RUN: go to HALT next cycle if `run`=0, or if `bkpt`=1 while `adv`=1.
  - STEP: go to HALT on the first cycle with `adv`=1; stay in STEP while stalled. `run` is ignored in STEP.
- A step edge is captured only in HALT; edges seen in other states are discarded. The `step` history register still updates every cycle.
- Combinational outputs, with active = RUN or STEP:
  - `adv` = active & ~`dmem_wait`
  - `bubble` = `adv` & `hazard` & ~`branch_taken`
  - `exec_en` = `adv`
  - `decode_en` = `adv` & ~`bubble`
  - `fetch_en` = `adv` & ~`bubble` & `imem_ready` & ~`branch_taken`
  - `pc_load` = `adv` & `branch_taken`
  - `fd_nop` = `adv` & ~`bubble` & (`branch_taken` | ~`imem_ready`)
  - `de_nop` = `adv` & (`bubble` | `branch_taken`)
- Priority on simultaneous events: `dmem_wait` > `branch_taken` > `hazard` > `imem_ready`.
- Breakpoint in the same cycle as a branch: the branch completes (`pc_load`=1), then the block halts.
- `adv_cnt` increments by 1 on every `adv` cycle and wraps from 2^CNT_W-1 to 0. It is not cleared by HALT.

## Timing
- Enables, NOP strobes and `pc_load` have zero latency: they are combinational from the registered state and the current inputs.
- `state`, `halted` and `adv_cnt` are registered and update one cycle after the causing condition.
- Reset values, applied immediately while `reset_n`=0: `state`=INIT, down-counter=`STARTUP_CYCLES`-1, `adv_cnt`=0, step history=0. All enables and strobes read 0, `halted`=0.
- A reset asserted mid-operation, including mid-STEP or mid-stall, aborts with no further enables. INIT re-runs after release.
- First possible `adv` comes `STARTUP_CYCLES` cycles after reset release, with `run`=1 held.
- A step edge in HALT reaches STEP on the next cycle. Exactly one `adv` cycle occurs before HALT, however many stall cycles come in between.

## Structure
- Shared package `xm23_pkg`:
  - `pipe_state_t` enum (INIT, HALT, RUN, STEP);
  - `XM23_NOP` = `16'h0000`;
  - `XM23_WORD_W` = 16.
- Single module, no sub-module. The edge detector and the startup counter are inline registers. The output equations live in one `always_comb`.

## Test plan
- Reset release with `run`=1, `STARTUP_CYCLES`=4: `state`=INIT for 4 cycles, then RUN; `exec_en`=1 on cycle 5; `adv_cnt`=1 after cycle 5.
- RUN with `hazard`=1 for one cycle: `exec_en`=1, `decode_en`=0, `fetch_en`=0, `de_nop`=1, `fd_nop`=0.
- RUN with `branch_taken`=1 and `hazard`=1 together: `pc_load`=1, `fd_nop`=1, `de_nop`=1, `decode_en`=1, `fetch_en`=0.
- HALT, pulse `step` with `dmem_wait`=1 for 3 cycles: STEP holds for 3 cycles with `exec_en`=0; exactly one `exec_en` pulse follows, then `halted`=1; `adv_cnt` rises by exactly 1.
- RUN with `bkpt`=1 on an advance cycle: `state`=HALT the next cycle; a `step` edge during RUN produces no STEP afterwards.
- Preload `adv_cnt` near wrap with `CNT_W`=4 and run 20 cycles: the count wraps 15 to 0. Assert `reset_n`=0 mid-RUN: all enables 0 in the same cycle and `state`=INIT.
